// File: rtl/dpram_avalon_master_pkg.sv
// Shared constants for the dpRam Avalon-MM initiator: bus geometry,
// slave command codes and the sequencer state encoding.
package dpram_avalon_master_pkg;

    localparam int LANE_W    = 32;
    localparam int AV_ADDR_W = 5;

    localparam logic [LANE_W-1:0] CMD_COMMIT = 32'd1;
    localparam logic [LANE_W-1:0] CMD_FETCH  = 32'd2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_SET_ADDR = 3'd1;
    localparam state_t ST_WR_LANE  = 3'd2;
    localparam state_t ST_COMMIT   = 3'd3;
    localparam state_t ST_FETCH    = 3'd4;
    localparam state_t ST_RD_ISSUE = 3'd5;
    localparam state_t ST_RD_WAIT  = 3'd6;
    localparam state_t ST_DONE     = 3'd7;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpram_avalon_master_lane_gearbox.sv
// Lane gearbox: picks the 32-bit lane of the outgoing word addressed by the
// lane counter, and merges an incoming 32-bit lane into the word being read.
module lane_gearbox
    import dpram_avalon_master_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int LANE_CNT_W = 3
) (
    input  logic [LANE_CNT_W-1:0] i_lane,
    input  logic [DATA_WIDTH-1:0] i_wr_word,
    output logic [LANE_W-1:0]     o_wr_lane,
    input  logic [DATA_WIDTH-1:0] i_rd_word,
    input  logic [LANE_W-1:0]     i_rd_lane,
    output logic [DATA_WIDTH-1:0] o_rd_word
);

    assign o_wr_lane = i_wr_word[int'(i_lane) * LANE_W +: LANE_W];

    // Replace the addressed lane of the partially assembled read word.
    always_comb begin
        // NOTE: full default first so every bit has a value on every path; no latch.
        o_rd_word = i_rd_word;
        o_rd_word[int'(i_lane) * LANE_W +: LANE_W] = i_rd_lane;
    end

endmodule

// File: rtl/dpram_avalon_master.sv
// Avalon-MM initiator moving whole RAM words to and from a dpRam-style
// 32-bit register slave: address-set, lane writes, commit for writes;
// address-set, fetch, lane reads with reassembly for reads.
module dpram_avalon_master
    import dpram_avalon_master_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int LANE_BASE  = 0,
    parameter int ADDR_REG   = 8,
    parameter int CMD_REG    = 9,
    parameter int RD_LAT     = 1,
    parameter int FETCH_WAIT = 2
) (
    input  logic                  avalon_clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_index,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy,
    output logic                  av_read,
    output logic                  av_write,
    output logic [AV_ADDR_W-1:0]  av_address,
    output logic [LANE_W-1:0]     av_writedata,
    input  logic [LANE_W-1:0]     av_readdata,
    input  logic                  av_waitrequest
);

    localparam int LANES      = DATA_WIDTH / LANE_W;
    localparam int LANE_CNT_W = cnt_width(LANES);
    localparam int WAIT_MAX   = (FETCH_WAIT > RD_LAT) ? FETCH_WAIT : RD_LAT;
    localparam int WAIT_W     = cnt_width(WAIT_MAX);

    localparam logic [LANE_CNT_W-1:0] LANE_LAST  = LANE_CNT_W'(LANES - 1);
    localparam logic [WAIT_W-1:0]     FETCH_LAST = WAIT_W'((FETCH_WAIT > 0) ? FETCH_WAIT - 1 : 0);
    localparam logic [WAIT_W-1:0]     RD_LAST    = WAIT_W'(RD_LAT - 1);

    state_t                r_state;
    logic [LANE_CNT_W-1:0] r_lane;
    logic [WAIT_W-1:0]     r_wait;
    logic                  r_fetch_sent;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_index;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_rd_word;
    logic [DATA_WIDTH-1:0] r_resp_data;

    logic [LANE_W-1:0]     w_lane_wdata;
    logic [DATA_WIDTH-1:0] w_rd_word_next;
    logic [AV_ADDR_W-1:0]  w_lane_addr;

    lane_gearbox #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANE_CNT_W (LANE_CNT_W)
    ) u_gearbox (
        .i_lane    (r_lane),
        .i_wr_word (r_data),
        .o_wr_lane (w_lane_wdata),
        .i_rd_word (r_rd_word),
        .i_rd_lane (av_readdata),
        .o_rd_word (w_rd_word_next)
    );

    assign w_lane_addr = AV_ADDR_W'(LANE_BASE) + AV_ADDR_W'(r_lane);
    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign resp_valid  = (r_state == ST_DONE);
    assign resp_data   = r_resp_data;

    // Sequencer: latches the request and steps through the bus phases.
    always_ff @(posedge avalon_clk) begin
        // NOTE: non-blocking everywhere so every register sees pre-edge values.
        if (reset) begin
            r_state      <= ST_IDLE;
            r_lane       <= '0;
            r_wait       <= '0;
            r_fetch_sent <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write      <= req_write;
                        r_index      <= req_index;
                        r_data       <= req_data;
                        r_lane       <= '0;
                        r_wait       <= '0;
                        r_fetch_sent <= 1'b0;
                        r_state      <= ST_SET_ADDR;
                    end
                end
                ST_SET_ADDR: begin
                    if (!av_waitrequest) begin
                        r_state <= r_write ? ST_WR_LANE : ST_FETCH;
                    end
                end
                ST_WR_LANE: begin
                    if (!av_waitrequest) begin
                        if (r_lane == LANE_LAST) begin
                            r_lane  <= '0;
                            r_state <= ST_COMMIT;
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (!av_waitrequest) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_FETCH: begin
                    if (!r_fetch_sent) begin
                        if (!av_waitrequest) begin
                            r_wait <= '0;
                            if (FETCH_WAIT == 0) begin
                                r_state <= ST_RD_ISSUE;
                            end else begin
                                r_fetch_sent <= 1'b1;
                            end
                        end
                    end else if (r_wait == FETCH_LAST) begin
                        r_wait       <= '0;
                        r_fetch_sent <= 1'b0;
                        r_state      <= ST_RD_ISSUE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_RD_ISSUE: begin
                    if (!av_waitrequest) begin
                        r_wait  <= '0;
                        r_state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (r_wait == RD_LAST) begin
                        r_wait    <= '0;
                        r_rd_word <= w_rd_word_next;
                        if (r_lane == LANE_LAST) begin
                            r_lane      <= '0;
                            r_resp_data <= w_rd_word_next;
                            r_state     <= ST_DONE;
                        end else begin
                            r_lane  <= r_lane + 1'b1;
                            r_state <= ST_RD_ISSUE;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
    // NOTE: r_write/r_index/r_data/r_rd_word carry no reset; they are always
    // loaded before being used, so clearing them buys nothing.

    // Bus drive decoded from the registered state; held while waitrequest stalls.
    always_comb begin
        av_read      = 1'b0;
        av_write     = 1'b0;
        av_address   = '0;
        av_writedata = '0;
        case (r_state)
            ST_SET_ADDR: begin
                av_write     = 1'b1;
                av_address   = AV_ADDR_W'(ADDR_REG);
                av_writedata = LANE_W'(r_index);
            end
            ST_WR_LANE: begin
                av_write     = 1'b1;
                av_address   = w_lane_addr;
                av_writedata = w_lane_wdata;
            end
            ST_COMMIT: begin
                av_write     = 1'b1;
                av_address   = AV_ADDR_W'(CMD_REG);
                av_writedata = CMD_COMMIT;
            end
            ST_FETCH: begin
                if (!r_fetch_sent) begin
                    av_write     = 1'b1;
                    av_address   = AV_ADDR_W'(CMD_REG);
                    av_writedata = CMD_FETCH;
                end
            end
            ST_RD_ISSUE: begin
                av_read    = 1'b1;
                av_address = w_lane_addr;
            end
            default: begin
            end
        endcase
    end

endmodule
